// File: rtl/uv_i2c_pinctl_if.sv
// Engine-side bundle of the I2C pin controller: line drive requests from the
// engine, filtered line values and bus status back to it.
interface uv_i2c_pinctl_if;
    logic core_scl_out;
    logic core_sda_out;
    logic core_scl_oen;
    logic core_sda_oen;
    logic core_scl_in;
    logic core_sda_in;
    logic bus_start;
    logic bus_stop;
    logic bus_busy;
    logic arb_lost;
    logic scl_stretch;

    // I2C engine side
    modport master (
        output core_scl_out, core_sda_out, core_scl_oen, core_sda_oen,
        input  core_scl_in, core_sda_in,
        input  bus_start, bus_stop, bus_busy, arb_lost, scl_stretch
    );

    // pin controller side
    modport slave (
        input  core_scl_out, core_sda_out, core_scl_oen, core_sda_oen,
        output core_scl_in, core_sda_in,
        output bus_start, bus_stop, bus_busy, arb_lost, scl_stretch
    );
endinterface

// File: rtl/uv_i2c_filt.sv
// One I2C line: metastability synchronizer followed by a spike filter.
// The filtered value only follows the synchronized value after it has
// disagreed for flt_len + 1 consecutive cycles.
module uv_i2c_filt #(
    parameter int FLT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_in,
    input  logic [FLT_W-1:0] flt_len,
    output logic             filt_out
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic [FLT_W-1:0]       cnt_q, cnt_d;
    logic                   synced;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign filt_out = filt_q;

    // Next-state: shift the synchronizer and run the disagreement counter.
    // ">=" rather than "==" so a length lowered below the running count
    // still lets the filtered value update on the next cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (synced == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= flt_len) begin
            filt_d = synced;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; an idle I2C line is high, so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/uv_i2c_pinctl.sv
// I2C pad controller: open-drain pad drive, filtered line inputs, START/STOP
// detection, bus-busy tracking, arbitration-loss and clock-stretch detection.
module uv_i2c_pinctl #(
    parameter int FLT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic [FLT_W-1:0] cfg_flt_len,
    input  logic             pad_scl_in,
    input  logic             pad_sda_in,
    output logic             pad_scl_out,
    output logic             pad_sda_out,
    output logic             pad_scl_oen,
    output logic             pad_sda_oen,
    uv_i2c_pinctl_if.slave   core
);
    // threshold is formed two bits wider so the sum cannot wrap
    localparam int CW = FLT_W + 2;

    logic             scl_f, sda_f;
    logic             scl_prev_q, scl_prev_d;
    logic             sda_prev_q, sda_prev_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             busy_q, busy_d;
    logic             arb_q, arb_d;
    logic [FLT_W-1:0] stretch_cnt_q, stretch_cnt_d;
    logic [CW-1:0]    stretch_thr;

    uv_i2c_filt #(.FLT_W(FLT_W), .SYNC_STAGES(SYNC_STAGES)) u_filt_scl (
        .clk(clk), .rst(rst), .pad_in(pad_scl_in), .flt_len(cfg_flt_len), .filt_out(scl_f)
    );

    uv_i2c_filt #(.FLT_W(FLT_W), .SYNC_STAGES(SYNC_STAGES)) u_filt_sda (
        .clk(clk), .rst(rst), .pad_in(pad_sda_in), .flt_len(cfg_flt_len), .filt_out(sda_f)
    );

    // Open-drain: only ever pull low; reset releases the pads without a clock.
    assign pad_scl_out = 1'b0;
    assign pad_sda_out = 1'b0;
    assign pad_scl_oen = rst | ~(cfg_en & ~core.core_scl_oen & ~core.core_scl_out);
    assign pad_sda_oen = rst | ~(cfg_en & ~core.core_sda_oen & ~core.core_sda_out);

    assign core.core_scl_in = scl_f;
    assign core.core_sda_in = sda_f;

    assign stretch_thr = CW'(cfg_flt_len) + CW'(SYNC_STAGES + 1);

    // Status outputs are also gated by cfg_en so disabling takes effect at once.
    assign core.bus_start   = start_q & cfg_en;
    assign core.bus_stop    = stop_q & cfg_en;
    assign core.bus_busy    = busy_q & cfg_en;
    assign core.arb_lost    = arb_q & cfg_en;
    assign core.scl_stretch = cfg_en & (CW'(stretch_cnt_q) > stretch_thr);

    // Bus-condition detection on the filtered lines. Requiring SCL stable
    // high across both cycles also rejects simultaneous SCL/SDA edges.
    always_comb begin
        scl_prev_d    = scl_f;
        sda_prev_d    = sda_f;
        start_d       = cfg_en & scl_prev_q & scl_f & sda_prev_q & ~sda_f;
        stop_d        = cfg_en & scl_prev_q & scl_f & ~sda_prev_q & sda_f;
        arb_d         = cfg_en & busy_q & ~scl_prev_q & scl_f & ~sda_f
                        & (core.core_sda_oen | core.core_sda_out);
        busy_d        = busy_q;
        stretch_cnt_d = '0;
        if (!cfg_en) begin
            busy_d = 1'b0;
        end else if (start_q) begin
            busy_d = 1'b1;
        end else if (stop_q) begin
            busy_d = 1'b0;
        end
        if (cfg_en && (core.core_scl_oen || core.core_scl_out) && !scl_f) begin
            stretch_cnt_d = (stretch_cnt_q == '1) ? stretch_cnt_q : stretch_cnt_q + 1'b1;
        end
    end

    // Detector and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q    <= 1'b1;
            sda_prev_q    <= 1'b1;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            busy_q        <= 1'b0;
            arb_q         <= 1'b0;
            stretch_cnt_q <= '0;
        end else begin
            scl_prev_q    <= scl_prev_d;
            sda_prev_q    <= sda_prev_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            busy_q        <= busy_d;
            arb_q         <= arb_d;
            stretch_cnt_q <= stretch_cnt_d;
        end
    end
endmodule

// File: tb/tb_uv_i2c_pinctl.sv
// Directed bench for uv_i2c_pinctl: a vector table for the combinational pad
// drive, then hand-timed sequences for filter, bus conditions and reset.
module tb_uv_i2c_pinctl;
    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_en;
    logic [3:0] cfg_flt_len;
    logic       pad_scl_in, pad_sda_in;
    logic       pad_scl_out, pad_sda_out, pad_scl_oen, pad_sda_oen;

    int passed = 0;
    int total  = 0;

    uv_i2c_pinctl_if bus ();

    uv_i2c_pinctl #(.FLT_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_flt_len(cfg_flt_len),
        .pad_scl_in(pad_scl_in), .pad_sda_in(pad_sda_in),
        .pad_scl_out(pad_scl_out), .pad_sda_out(pad_sda_out),
        .pad_scl_oen(pad_scl_oen), .pad_sda_oen(pad_sda_oen),
        .core(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en, scl_out, scl_oen, sda_out, sda_oen;
        logic exp_scl_oen, exp_sda_oen;
    } oen_vec_t;

    oen_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic [4:0] status();
        return {bus.bus_start, bus.bus_stop, bus.bus_busy, bus.arb_lost, bus.scl_stretch};
    endfunction

    task automatic defaults();
        cfg_en = 1'b1;
        pad_scl_in = 1'b1;
        pad_sda_in = 1'b1;
        bus.core_scl_out = 1'b1;
        bus.core_sda_out = 1'b1;
        bus.core_scl_oen = 1'b1;
        bus.core_sda_oen = 1'b1;
    endtask

    task automatic do_reset(input logic [3:0] len);
        defaults();
        cfg_flt_len = len;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(3);
    endtask

    initial begin
        int n_start, n_stop, n_arb, min_busy, min_sda;

        vecs[0] = '{1, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 0, 1, 0, 1, 1};
        vecs[2] = '{1, 0, 1, 0, 1, 1, 1};
        vecs[3] = '{1, 0, 0, 1, 1, 0, 1};
        vecs[4] = '{1, 1, 1, 0, 0, 1, 0};
        vecs[5] = '{0, 0, 0, 0, 0, 1, 1};
        vecs[6] = '{0, 1, 0, 0, 1, 1, 1};
        vecs[7] = '{1, 1, 0, 0, 0, 1, 0};

        // reset state, before any clock edge
        defaults();
        cfg_flt_len = 4'd0;
        rst = 1'b1;
        #2;
        check("rst_core_scl_in", bus.core_scl_in, 1);
        check("rst_core_sda_in", bus.core_sda_in, 1);
        check("rst_status", status(), 0);
        check("rst_pad_oen", {pad_scl_oen, pad_sda_oen}, 2'b11);
        check("rst_pad_out", {pad_scl_out, pad_sda_out}, 2'b00);
        ticks(2);
        rst = 1'b0;
        ticks(3);

        // combinational pad drive table
        for (int i = 0; i < 8; i++) begin
            cfg_en = vecs[i].en;
            bus.core_scl_out = vecs[i].scl_out;
            bus.core_scl_oen = vecs[i].scl_oen;
            bus.core_sda_out = vecs[i].sda_out;
            bus.core_sda_oen = vecs[i].sda_oen;
            #1;
            check($sformatf("oen_vec%0d", i), {pad_scl_oen, pad_sda_oen},
                  {vecs[i].exp_scl_oen, vecs[i].exp_sda_oen});
            check($sformatf("out_vec%0d", i), {pad_scl_out, pad_sda_out}, 2'b00);
        end

        // glitch filter, length 3: 3-cycle spike blocked, 4-cycle accepted
        do_reset(4'd3);
        pad_sda_in = 1'b0;
        ticks(3);
        pad_sda_in = 1'b1;
        min_sda = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.core_sda_in !== 1'b1) min_sda = 0;
        end
        check("glitch3_blocked", min_sda, 1);
        pad_sda_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 4) pad_sda_in = 1'b1;
            if (i == 5) check("glitch4_before_fall", bus.core_sda_in, 1);
            if (i == 6) check("glitch4_fall_at_6", bus.core_sda_in, 0);
            if (i == 9) check("glitch4_still_low", bus.core_sda_in, 0);
            if (i == 10) check("glitch4_rise_at_10", bus.core_sda_in, 1);
        end

        // filter length lowered below a running count
        do_reset(4'd7);
        pad_sda_in = 1'b0;
        ticks(5);
        check("lenchg_before", bus.core_sda_in, 1);
        cfg_flt_len = 4'd1;
        tick();
        check("lenchg_update", bus.core_sda_in, 0);

        // START then STOP, length 0
        do_reset(4'd0);
        pad_sda_in = 1'b0;
        n_start = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_start += int'(bus.bus_start);
            if (i == 3) check("start_not_yet", bus.bus_start, 0);
            if (i == 4) check("start_pulse", {bus.bus_start, bus.bus_busy}, 2'b10);
            if (i == 5) check("busy_after_start", {bus.bus_start, bus.bus_busy}, 2'b01);
        end
        check("start_count", n_start, 1);
        pad_sda_in = 1'b1;
        n_stop = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_stop += int'(bus.bus_stop);
            if (i == 4) check("stop_pulse", {bus.bus_stop, bus.bus_busy}, 2'b11);
            if (i == 5) check("idle_after_stop", {bus.bus_stop, bus.bus_busy}, 2'b00);
        end
        check("stop_count", n_stop, 1);

        // repeated START keeps busy
        pad_sda_in = 1'b0;
        ticks(6);
        pad_scl_in = 1'b0;
        ticks(5);
        pad_sda_in = 1'b1;
        ticks(5);
        pad_scl_in = 1'b1;
        ticks(5);
        pad_sda_in = 1'b0;
        n_start = 0;
        min_busy = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_start += int'(bus.bus_start);
            if (bus.bus_busy !== 1'b1) min_busy = 0;
        end
        check("rstart_count", n_start, 1);
        check("rstart_busy_held", min_busy, 1);

        // arbitration: engine driving low -> no loss; engine driving 1 -> loss
        pad_scl_in = 1'b0;
        bus.core_sda_oen = 1'b0;
        bus.core_sda_out = 1'b0;
        ticks(5);
        pad_scl_in = 1'b1;
        n_arb = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_arb += int'(bus.arb_lost);
        end
        check("arb_engine_low", n_arb, 0);
        pad_scl_in = 1'b0;
        ticks(5);
        bus.core_sda_out = 1'b1;
        pad_scl_in = 1'b1;
        n_arb = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_arb += int'(bus.arb_lost);
        end
        check("arb_lost_once", n_arb, 1);

        // asynchronous reset mid-transfer
        bus.core_sda_oen = 1'b0;
        bus.core_sda_out = 1'b0;
        #1;
        check("pre_rst_sda_pull", pad_sda_oen, 0);
        check("pre_rst_busy", bus.bus_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_sda_oen", pad_sda_oen, 1);
        check("rst_async_status", status(), 0);
        ticks(1);
        rst = 1'b0;

        // clock stretch, length 0: threshold count is 3
        do_reset(4'd0);
        pad_scl_in = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("stretch_t%0d", i), bus.scl_stretch, (i >= 7 && i <= 13) ? 1 : 0);
            if (i == 10) pad_scl_in = 1'b1;
        end

        // disabled block: pads released, lines still tracked, no status
        do_reset(4'd0);
        cfg_en = 1'b0;
        bus.core_scl_oen = 1'b0;
        bus.core_scl_out = 1'b0;
        bus.core_sda_oen = 1'b0;
        bus.core_sda_out = 1'b0;
        #1;
        check("dis_pad_oen", {pad_scl_oen, pad_sda_oen}, 2'b11);
        pad_sda_in = 1'b0;
        n_start = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_start += int'(bus.bus_start | bus.bus_busy);
        end
        check("dis_no_start", n_start, 0);
        check("dis_sda_tracks", bus.core_sda_in, 0);
        bus.core_scl_oen = 1'b1;
        pad_scl_in = 1'b0;
        n_arb = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_arb += int'(bus.scl_stretch);
        end
        check("dis_scl_tracks", bus.core_scl_in, 0);
        check("dis_no_stretch", n_arb, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
